// File: rtl/imem_loader.sv
// Boot loader: receives a byte stream (word count, big-endian words, XOR checksum),
// writes the words into instruction memory and holds the CPU in reset until a load succeeds.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [31:0] MAX_U = 32'(MAX_WORDS);

    logic [2:0]        state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        acc_q, acc_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              accept;
    logic              last_word;

    assign byte_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign busy       = byte_ready;
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign cpu_rst    = (state_q != S_DONE);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    assign accept    = byte_valid && byte_ready;
    // Compared at 32 bits so the check holds for any ADDR_W against the 8-bit count.
    assign last_word = (32'(cnt_q) == (32'(n_q) - 32'd1));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                    acc_d   = 8'd0;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    n_d     = byte_data;
                    acc_d   = acc_q ^ byte_data;
                    state_d = ((byte_data == 8'd0) || (32'(byte_data) > MAX_U)) ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d = {asm_q[15:0], byte_data};
                    acc_d = acc_q ^ byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q;
                        wdata_d = {asm_q, byte_data};
                        cnt_d   = cnt_q + ADDR_W'(1);
                        if (last_word) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) state_d = (byte_data == acc_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= 8'd0;
            acc_q   <= 8'd0;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            asm_q   <= 24'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table, reset/abort and full-size sequences, and
// randomized streams checked against a stream-level reference model.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(255)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    typedef logic [ADDR_W+31:0] wr_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] stream[$];
    wr_t        wq[$];
    wr_t        ew[$];
    logic       mdone;
    logic       merr;

    // Every write strobe seen by memory, recorded as {addr, data}.
    always @(negedge clk) if (imem_we) wq.push_back({imem_addr, imem_wdata});

    task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    task automatic add_csum(input logic [7:0] flip);
        logic [7:0] x;
        x = 8'd0;
        foreach (stream[i]) x = x ^ stream[i];
        stream.push_back(x ^ flip);
    endtask

    // Reference: decode the whole stream by the format rules.
    task automatic model();
        int         n;
        logic [7:0] acc;
        logic [31:0] w;
        ew.delete();
        mdone = 1'b0;
        merr  = 1'b0;
        n     = int'(stream[0]);
        acc   = stream[0];
        if (n == 0 || n > 255) begin
            merr = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = 32'd0;
            for (int b = 0; b < 4; b++) begin
                w   = {w[23:0], stream[1 + 4*k + b]};
                acc = acc ^ stream[1 + 4*k + b];
            end
            ew.push_back({ADDR_W'(k), w});
        end
        mdone = (stream[1 + 4*n] == acc);
        merr  = !mdone;
    endtask

    task automatic run(input int maxgap, input int start_at, output int cyc);
        int g;
        wq.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        for (int i = 0; i < stream.size(); i++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clk);
                cyc++;
            end
            if (!byte_ready) begin
                checks++;
                errors++;
                $display("FAIL stall: byte_ready=0 at stream byte %0d of %0d", i, stream.size());
                break;
            end
            byte_valid = 1'b1;
            byte_data  = stream[i];
            start      = (i == start_at);
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        byte_valid = 1'b0;
    endtask

    task automatic check_end(input string tag);
        wr_t last;
        ck({tag, "_nwrites"}, 64'(wq.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < wq.size(); i++) ck({tag, "_write"}, 64'(wq[i]), 64'(ew[i]));
        ck({tag, "_done"}, 64'(done), 64'(mdone));
        ck({tag, "_err"}, 64'(err), 64'(merr));
        ck({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(!mdone));
        ck({tag, "_busy"}, 64'(busy), 64'd0);
        ck({tag, "_ready"}, 64'(byte_ready), 64'd0);
        ck({tag, "_we_idle"}, 64'(imem_we), 64'd0);
        if (ew.size() > 0) begin
            last = ew[ew.size()-1];
            ck({tag, "_addr_hold"}, 64'(imem_addr), 64'(last[ADDR_W+31:32]));
            ck({tag, "_wdata_hold"}, 64'(imem_wdata), 64'(last[31:0]));
        end
    endtask

    typedef struct {
        logic [7:0]  n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  flip;
        int          maxgap;
        logic        exp_done;
        logic        exp_err;
        int          exp_nw;
    } vec_t;

    vec_t tbl[5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        int  n;
        wr_t tmp;

        tbl[0] = '{8'd2, 32'h20080005, 32'h2009000A, 8'h00, 0, 1'b1, 1'b0, 2};
        tbl[1] = '{8'd2, 32'h20080005, 32'h2009000A, 8'h01, 0, 1'b0, 1'b1, 2};
        tbl[2] = '{8'd0, 32'h0, 32'h0, 8'h00, 0, 1'b0, 1'b1, 0};
        tbl[3] = '{8'd2, 32'h20080005, 32'h2009000A, 8'h00, 5, 1'b1, 1'b0, 2};
        tbl[4] = '{8'd1, 32'hDEADBEEF, 32'h0, 8'h00, 2, 1'b1, 1'b0, 1};

        #1;
        ck("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        ck("rst_busy", 64'(busy), 64'd0);
        ck("rst_done_err", 64'({done, err}), 64'd0);
        ck("rst_we_ready", 64'({imem_we, byte_ready}), 64'd0);
        ck("rst_addr_data", 64'({imem_addr, imem_wdata}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        ck("idle_cpu_rst", 64'(cpu_rst), 64'd1);
        ck("idle_busy_ready", 64'({busy, byte_ready}), 64'd0);

        for (int t = 0; t < 5; t++) begin
            stream.delete();
            stream.push_back(tbl[t].n);
            if (tbl[t].n >= 8'd1) add_word(tbl[t].w0);
            if (tbl[t].n >= 8'd2) add_word(tbl[t].w1);
            if (tbl[t].n != 8'd0) add_csum(tbl[t].flip);
            model();
            run(tbl[t].maxgap, -1, cyc);
            check_end($sformatf("vec%0d", t));
            ck($sformatf("vec%0d_tbl_nw", t), 64'(wq.size()), 64'(tbl[t].exp_nw));
            ck($sformatf("vec%0d_tbl_done", t), 64'(done), 64'(tbl[t].exp_done));
            ck($sformatf("vec%0d_tbl_err", t), 64'(err), 64'(tbl[t].exp_err));
            if (tbl[t].exp_nw > 0 && wq.size() > 0)
                ck($sformatf("vec%0d_tbl_w0", t), 64'(wq[0]), 64'({ADDR_W'(0), tbl[t].w0}));
            if (tbl[t].maxgap == 0 && tbl[t].n != 8'd0)
                ck($sformatf("vec%0d_b2b_cycles", t), 64'(cyc), 64'(stream.size()));
        end

        // Abort a load with reset after the header and five payload bytes.
        stream.delete();
        stream.push_back(8'd2);
        add_word(32'h20080005);
        add_word(32'h2009000A);
        add_csum(8'h00);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            byte_valid = 1'b1;
            byte_data  = stream[i];
            @(negedge clk);
        end
        byte_valid = 1'b0;
        rst = 1'b0;
        #1;
        wq.delete();
        ck("abort_cpu_rst", 64'(cpu_rst), 64'd1);
        ck("abort_flags", 64'({busy, done, err, imem_we, byte_ready}), 64'd0);
        ck("abort_addr_data", 64'({imem_addr, imem_wdata}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        ck("abort_no_writes", 64'(wq.size()), 64'd0);
        ck("abort_idle_cpu_rst", 64'(cpu_rst), 64'd1);
        model();
        run(0, -1, cyc);
        check_end("after_abort");

        // Full-size load with a start pulse landing mid-payload.
        stream.delete();
        stream.push_back(8'd255);
        for (int k = 0; k < 255; k++) add_word($urandom);
        add_csum(8'h00);
        model();
        run(0, 100, cyc);
        check_end("full");
        if (wq.size() > 0) begin
            tmp = wq[wq.size()-1];
            ck("full_last_addr", 64'(tmp[ADDR_W+31:32]), 64'd254);
        end

        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(6, 0));
            stream.delete();
            stream.push_back(8'(n));
            for (int k = 0; k < n; k++) add_word($urandom);
            if (n != 0) add_csum(($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00);
            model();
            run(int'($urandom_range(3, 0)), -1, cyc);
            check_end($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, is the instruction-memory word-address width.
REQ-002 Parameter MAX_WORDS, default 255, is the largest accepted word count and SHALL be at most 2**ADDR_W.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: a one-cycle pulse that begins a program load.
REQ-006 Port byte_valid, input, 1: the source presents a byte on byte_data.
REQ-007 Port byte_data, input, 8: the stream byte.
REQ-008 Port byte_ready, output, 1: the loader accepts a byte this cycle.
REQ-009 Port imem_we, output, 1: write strobe to instruction memory.
REQ-010 Port imem_addr, output, ADDR_W: word address of the write.
REQ-011 Port imem_wdata, output, 32: the instruction word to write.
REQ-012 Port cpu_rst, output, 1: active-high hold applied to the pipeline rst.
REQ-013 Port busy, output, 1: a load is in progress.
REQ-014 Port done, output, 1: the last load completed with a correct checksum.
REQ-015 Port err, output, 1: the last load failed.

Function
REQ-016 Stream format SHALL be: header byte N (word count); then N words of 4 bytes each, most significant byte first; then one checksum byte.
REQ-017 The checksum SHALL equal the XOR of the header byte and all payload bytes.
REQ-018 A byte is accepted only in a cycle where byte_valid and byte_ready are both 1; when byte_valid=0, no state advances.
REQ-019 The state machine SHALL have the states IDLE, HDR, DATA, CSUM, DONE and ERR.
REQ-020 byte_ready SHALL be 1 in HDR, DATA and CSUM, and 0 in all other states.
REQ-021 On start=1 in IDLE, DONE or ERR:
- next state is HDR;
- cpu_rst=1, busy=1, done=0, err=0;
- the XOR accumulator, word counter and byte index are cleared.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 In HDR, on accept:
- N is latched and the accumulator ^= byte;
- if N==0 or N>MAX_WORDS, next state is ERR;
- otherwise, next state is DATA.
REQ-024 In DATA, on each accept:
- the assembly register shifts left by 8, with the new byte entering bits 7:0;
- the accumulator ^= byte;
- the byte index increments modulo 4.
REQ-025 On the accept with byte index 3, the cycle after that edge SHALL carry:
- imem_we=1 for exactly one cycle;
- imem_addr = word counter;
- imem_wdata = the assembled word.
REQ-026 After each completed word the word counter increments; on completing word N-1 the next state is CSUM.
REQ-027 In CSUM, on accept: the next state is DONE if the byte equals the accumulator, otherwise ERR.
REQ-028 DONE SHALL drive done=1, busy=0 and cpu_rst=0, and is held until start.
REQ-029 ERR SHALL drive err=1, busy=0 and cpu_rst=1, and is held until start.
REQ-030 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.
REQ-031 done and err SHALL never both be 1.
REQ-032 Back-to-back bytes, one accepted every cycle, SHALL be sustained with no stall.

Reset
REQ-033 While rst=0, regardless of state:
- state is IDLE;
- cpu_rst=1;
- busy=0, done=0, err=0, imem_we=0, byte_ready=0;
- imem_addr=0 and imem_wdata=0;
- all counters and the accumulator are 0.
REQ-034 Reset asserted mid-load SHALL abort the load, and no further imem_we pulses SHALL occur for that load.
REQ-035 After reset release the loader SHALL remain in IDLE with cpu_rst=1 until a successful load.

Verification
REQ-036 Good load: start, then bytes 02, 20 08 00 05, 20 09 00 0A, 0C -> imem_we at addr 0 with 0x20080005 and at addr 1 with 0x2009000A; then done=1, cpu_rst=0, err=0.
REQ-037 Bad checksum: the same stream ending in 0D instead of 0C -> both writes occur; then err=1, done=0, cpu_rst=1.
REQ-038 Zero header: start, then byte 00 -> ERR on the next cycle; no imem_we; byte_ready=0.
REQ-039 Gapped stream: the good-load stream with byte_valid randomly low for 0-5 cycles between bytes -> identical write sequence and done=1; a 2-word, 10-byte stream sent back-to-back completes in 10 accept cycles.
REQ-040 Mid-load reset: rst pulsed low after 5 DATA bytes -> all outputs at reset values immediately; a following full good load succeeds from addr 0.
REQ-041 Full-size load with ignored start: N=255, with start pulsed during DATA -> the start has no effect; the last write is to addr 254; done=1.
